mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between two requesters: the pipeline's instruction-fetch stage and its data-access (load/store) stage.
- Fixed priority, data over fetch: the data requester is the older instruction.
- Sequences each transaction through a small FSM with a req/ready handshake to memory.
- Returns read data and a one-cycle ack to the winning requester.
- The pipeline stalls its IF/MEM stages on missing ack.

Parameters:
XLEN, 32, data width of all data buses.
ADDR_W, 32, byte-address width.
TIMEOUT, 255, cycles to wait for mem_ready before flagging error (Optional Feature only).

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  synchronous, active-high.
i_req  in  1  fetch request; held with i_addr until i_ack.
i_addr  in  ADDR_W  fetch address.
i_kill  in  1  branch redirect; cancels the outstanding or pending fetch.
i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
i_rdata  out  XLEN  fetched instruction.
d_req  in  1  data request; held with d_addr/d_wen/d_wdata until d_ack.
d_addr  in  ADDR_W  data address.
d_wen  in  1  1=store, 0=load.
d_wdata  in  XLEN  store data.
d_ack  out  1  one-cycle pulse; d_rdata valid this cycle (loads).
d_rdata  out  XLEN  load data.
mem_req  out  1  memory request; held until mem_ready.
mem_addr  out  ADDR_W  memory address.
mem_wen  out  1  memory write enable.
mem_wdata  out  XLEN  memory write data.
mem_ready  in  1  memory completes the transaction this cycle; mem_rdata valid.
mem_rdata  in  XLEN  memory read data.
err  out  1  sticky timeout flag (Optional Feature only; tied 0 otherwise).

Behaviour:
- FSM states are IDLE, IBUSY and DBUSY.
- Reset values: state=IDLE; mem_req, mem_wen, i_ack, d_ack, err = 0; i_rdata, d_rdata, mem_addr, mem_wdata = 0.
- IDLE arbitration:
  - Eligible requester: req high and own ack not high this cycle. This masks the cycle in which the requester is still dropping req.
  - d eligible → DBUSY. Latch d_addr, d_wen and d_wdata into the mem_* registers; mem_req=1 next cycle.
  - Else i eligible and i_kill low → IBUSY with i_addr, mem_wen=0.
  - Else stay in IDLE.
- BUSY handling:
  - mem_* outputs are stable while mem_req=1.
  - On mem_ready: mem_req←0, mem_wen←0, state→IDLE.
  - Capture mem_rdata into i_rdata or d_rdata, and pulse the matching ack in the following cycle.
  - d_rdata is captured on stores too; its value is don't-care.
- Latency: request in cycle 0 (IDLE) → mem_req cycles 1..k, mem_ready in cycle k → ack in cycle k+1. Minimum is 2 cycles.
- Back-to-back: a new grant is possible in the ack cycle for the other requester only; same requester earliest in the cycle after its ack.
- Simultaneous d_req and i_req: data wins; fetch is granted after d_ack. Fetch may starve while data requests continue (accepted; the pipeline guarantees gaps).
- i_kill:
  - In IBUSY, or the cycle IBUSY completes: the memory transaction still completes, but i_ack is suppressed and i_rdata is not updated.
  - In IDLE: i_req is ignored that cycle.
  - i_kill has no effect on data transactions.
- Stores are never cancelled.
- Reset mid-transaction: returns to IDLE immediately and deasserts mem_req. The memory must tolerate the aborted request.
- i_ack and d_ack are never high in the same cycle.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entering BUSY and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT: err←1 (sticky until reset), the transaction is abandoned (mem_req←0, state→IDLE), and the matching ack is pulsed with rdata=0 so the pipeline does not hang.
- Undefined: no counter; err tied 0; the FSM waits indefinitely.

Decomposition:
- Shared package holds the state encoding (ARB_IDLE=2'd0, ARB_IBUSY=2'd1, ARB_DBUSY=2'd2) alongside the existing decoder constants.
- No sub-module required. The timeout counter may be a local always block under the macro.

Test Plan:
- Lone fetch: i_req, i_addr=0x40, memory replies mem_rdata=0x00500093 with one wait cycle → mem_req cycles 1–2, i_ack in cycle 3 with i_rdata=0x00500093, d_ack stays 0.
- Collision: d_req (load 0x100) and i_req (0x44) both raised in cycle 0 → data served first (mem_addr=0x100), d_ack pulses, then mem_addr=0x44 and i_ack; no overlap of acks.
- Store: d_req, d_wen=1, d_addr=0x200, d_wdata=0xDEADBEEF → mem_wen=1, mem_wdata=0xDEADBEEF while mem_req; d_ack after mem_ready; subsequent load of 0x200 returns 0xDEADBEEF from the memory model.
- Kill: fetch 0x48 in IBUSY, i_kill pulsed before mem_ready → transaction completes on memory, no i_ack, i_rdata unchanged; next fetch 0x80 acked normally.
- Reset mid-op: assert reset during DBUSY → next cycle mem_req=0, state IDLE, all acks 0; post-reset fetch works.
- With ARB_TIMEOUT_EN, TIMEOUT=4, mem_ready held 0 → after 4 BUSY cycles err=1, ack pulsed with rdata=0, FSM in IDLE; err stays 1 until reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter and the pipeline
// decode logic that feeds it.
//   - arb_state_t : arbiter FSM state encoding
//   - OPC_*       : base-ISA major opcodes used by the decoder
//   - is_mem_op() : true for opcodes that issue a data-port request
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2
    } arb_state_t;

    // Decoder major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Loads and stores are the only instructions that use the data port
    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (i_*) and data
// access (d_*). Data has fixed priority over fetch. Each transaction runs
// through IDLE -> IBUSY/DBUSY -> IDLE with a req/ready handshake to memory;
// the winner receives its read data with a one-cycle ack afterwards.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_req/i_addr/i_kill   fetch request, address, branch-redirect cancel
//   i_ack/i_rdata         fetch completion pulse and instruction word
//   d_req/d_addr/d_wen/   data request, address, store enable, store data
//   d_wdata
//   d_ack/d_rdata         data completion pulse and load data
//   mem_req/mem_addr/     memory request (held until mem_ready), address,
//   mem_wen/mem_wdata     write enable, write data
//   mem_ready/mem_rdata   memory completion and read data
//   err                   sticky timeout flag
//
// Optional build macro ARB_TIMEOUT_EN: adds a BUSY watchdog of TIMEOUT cycles.
// When it expires the transaction is abandoned, err is set (sticky until
// reset) and the requester is acked with zero data. Without the macro err is
// tied low and the FSM waits for mem_ready indefinitely.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_kill,
    output logic              i_ack,
    output logic [XLEN-1:0]   i_rdata,
    // data port
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wen,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_ack,
    output logic [XLEN-1:0]   d_rdata,
    // memory port
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    // status
    output logic              err
);

    arb_state_t state_r;
    // Remembers an i_kill seen earlier in the current fetch transaction
    logic       kill_r;
    // Watchdog expiry in the current BUSY cycle
    logic       timeout_s;
    // Requester eligibility: the own-ack term masks the cycle in which the
    // requester still holds req while it sees its ack
    logic       d_elig_s;
    logic       i_elig_s;

    assign d_elig_s = d_req && !d_ack;
    assign i_elig_s = i_req && !i_ack && !i_kill;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    // Watchdog counter: zero while idle, counts BUSY cycles without mem_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ARB_IDLE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!mem_ready) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The cycle that would make the count reach TIMEOUT is the expiry cycle
    assign timeout_s = (state_r != ARB_IDLE) && !mem_ready &&
                       (cnt_r == CNT_W'(TIMEOUT - 1));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Arbitration FSM with registered memory-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ARB_IDLE;
            kill_r    <= 1'b0;
            mem_req   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {XLEN{1'b0}};
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= {XLEN{1'b0}};
            d_rdata   <= {XLEN{1'b0}};
        end else begin
            // acks are single-cycle pulses
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (d_elig_s) begin
                        state_r   <= ARB_DBUSY;
                        mem_req   <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_wen   <= d_wen;
                        mem_wdata <= d_wdata;
                    end else if (i_elig_s) begin
                        state_r  <= ARB_IBUSY;
                        kill_r   <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= i_addr;
                        mem_wen  <= 1'b0;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_IBUSY: begin
                    if (mem_ready || timeout_s) begin
                        state_r <= ARB_IDLE;
                        mem_req <= 1'b0;
                        mem_wen <= 1'b0;
                        // a killed fetch still finishes on memory but is
                        // dropped silently towards the pipeline
                        if (!(kill_r || i_kill)) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_ready ? mem_rdata : {XLEN{1'b0}};
                        end else begin
                            i_ack <= 1'b0;
                        end
                    end else begin
                        kill_r <= kill_r || i_kill;
                    end
                end
                ARB_DBUSY: begin
                    if (mem_ready || timeout_s) begin
                        state_r <= ARB_IDLE;
                        mem_req <= 1'b0;
                        mem_wen <= 1'b0;
                        d_ack   <= 1'b1;
                        d_rdata <= mem_ready ? mem_rdata : {XLEN{1'b0}};
                    end else begin
                        state_r <= ARB_DBUSY;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                    mem_req <= 1'b0;
                    mem_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule
